// File: rtl/matrix_scan_driver_pkg.sv
// Shared definitions for the playfield row-scan driver.
//   NumRows/NumCols : default matrix geometry (12 rows x 16 columns)
//   RowIdxW         : width of the row_index output
//   scan_state_e    : scan FSM states
//   row_lsb()       : LSB position of a row inside the packed frame (row 0 = MSBs)
package matrix_scan_driver_pkg;

  localparam int unsigned NumRows = 12;
  localparam int unsigned NumCols = 16;
  localparam int unsigned RowIdxW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StBlank,
    StDrive
  } scan_state_e;

  // Row r occupies frame[(rows-1-r)*cols +: cols], so row 0 sits in the top bits.
  function automatic int unsigned row_lsb(input int unsigned row, input int unsigned rows,
                                          input int unsigned cols);
    return (rows - 1 - row) * cols;
  endfunction

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Frame-in / scan-out bundle of the row-scan driver.
//   enable     : 1 = scan, 0 = stop and blank            (master -> slave)
//   data       : ROWS*COLS frame, row 0 in the MSBs       (master -> slave)
//   row_sel    : one-hot active-high row enable           (slave -> master)
//   col_out    : column data of the lit row               (slave -> master)
//   row_index  : row currently in BLANK/DRIVE             (slave -> master)
//   frame_done : 1-cycle pulse after the last row's DRIVE (slave -> master)
interface matrix_scan_driver_if
  import matrix_scan_driver_pkg::*;
#(
  parameter int unsigned ROWS = NumRows,
  parameter int unsigned COLS = NumCols
);

  logic                   enable;
  logic [ROWS*COLS-1:0]   data;
  logic [ROWS-1:0]        row_sel;
  logic [COLS-1:0]        col_out;
  logic [RowIdxW-1:0]     row_index;
  logic                   frame_done;

  modport master (
    output enable,
    output data,
    input  row_sel,
    input  col_out,
    input  row_index,
    input  frame_done
  );

  modport slave (
    input  enable,
    input  data,
    output row_sel,
    output col_out,
    output row_index,
    output frame_done
  );

endinterface

// File: rtl/matrix_scan_driver_scan_timer.sv
// Loadable down-counter used to time both the BLANK and DRIVE intervals.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load_i   : load value_i into the counter this cycle
//   value_i  : load value (interval length minus one)
//   done_o   : terminal count; high while the counter is zero
// The counter stops at zero and never wraps.
module matrix_scan_driver_scan_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-scan driver for the LED playfield matrix.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of matrix_scan_driver_if (enable/data in, scan outputs out)
// The frame is copied into a shadow buffer once per pass (LOAD), so updates to data
// mid-pass never tear. Each row gets BLANK_CYCLES with all rows off (column data is
// updated here) followed by DWELL_CYCLES with the row lit. All outputs are registered;
// their next values are derived from the next state so they line up with state_q.
module matrix_scan_driver
  import matrix_scan_driver_pkg::*;
#(
  parameter int unsigned ROWS         = NumRows,
  parameter int unsigned COLS         = NumCols,
  parameter int unsigned DWELL_CYCLES = 5000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_scan_driver_if.slave  bus
);

  localparam int unsigned MaxCycles = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                     : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned FrameW    = ROWS * COLS;
  localparam int unsigned FrameIdxW = $clog2(FrameW);

  localparam logic [CntW-1:0]    DwellLoad = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0]    BlankLoad = CntW'(BLANK_CYCLES - 1);
  localparam logic [RowIdxW-1:0] LastRow   = RowIdxW'(ROWS - 1);

  scan_state_e          state_q, state_d;
  logic [FrameW-1:0]    shadow_q, shadow_d;
  logic [RowIdxW-1:0]   row_index_q, row_index_d;
  logic [ROWS-1:0]      row_sel_q, row_sel_d;
  logic [COLS-1:0]      col_out_q, col_out_d;
  logic                 frame_done_q, frame_done_d;
  logic [FrameIdxW-1:0] slice_lsb;

  logic            timer_load;
  logic [CntW-1:0] timer_value;
  logic            timer_done;

  matrix_scan_driver_scan_timer #(
    .Width (CntW)
  ) u_scan_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (timer_load),
    .value_i (timer_value),
    .done_o  (timer_done)
  );

  // Next-state, shadow and row counter.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    row_index_d  = row_index_q;
    frame_done_d = 1'b0;
    timer_load   = 1'b0;
    timer_value  = BlankLoad;

    if (!bus.enable) begin
      state_d     = StIdle;
      row_index_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StLoad;
        end
        StLoad: begin
          shadow_d    = bus.data;
          row_index_d = '0;
          timer_load  = 1'b1;
          timer_value = BlankLoad;
          state_d     = StBlank;
        end
        StBlank: begin
          if (timer_done) begin
            timer_load  = 1'b1;
            timer_value = DwellLoad;
            state_d     = StDrive;
          end
        end
        StDrive: begin
          if (timer_done) begin
            if (row_index_q == LastRow) begin
              row_index_d  = '0;
              frame_done_d = 1'b1;
              state_d      = StLoad;
            end else begin
              row_index_d = row_index_q + RowIdxW'(1);
              timer_load  = 1'b1;
              timer_value = BlankLoad;
              state_d     = StBlank;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output next values follow state_d so column data only moves while all rows are off.
  always_comb begin
    slice_lsb = FrameIdxW'(row_lsb(32'(row_index_d), ROWS, COLS));
    row_sel_d = '0;
    col_out_d = col_out_q;
    unique case (state_d)
      StIdle:  col_out_d = '0;
      StBlank: col_out_d = shadow_d[slice_lsb +: COLS];
      StDrive: row_sel_d = ROWS'(1) << row_index_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      row_index_q  <= '0;
      row_sel_q    <= '0;
      col_out_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      row_index_q  <= row_index_d;
      row_sel_q    <= row_sel_d;
      col_out_q    <= col_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.row_sel    = row_sel_q;
  assign bus.col_out    = col_out_q;
  assign bus.row_index  = row_index_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with DWELL_CYCLES=4, BLANK_CYCLES=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// cyc counts rising edges; with LOAD at cycle L, row r is blank at L+1+6r, L+2+6r and
// lit at L+3+6r .. L+6+6r; the next LOAD (with frame_done) is at L+73.
module tb_matrix_scan_driver;
  import matrix_scan_driver_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   t0;
  int   l_pass;
  int   fd_before;

  // Monitor counters.
  int            onehot_viol;
  int            stable_viol;
  int            index_viol;
  int            fd_count;
  logic [15:0]   prev_col;

  matrix_scan_driver_if #(.ROWS(12), .COLS(16)) bus ();

  matrix_scan_driver #(
    .ROWS         (12),
    .COLS         (16),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack(input logic [11:0] rs, input logic [15:0] co,
                                       input logic [3:0] ri, input logic fd);
    return {31'b0, rs, co, ri, fd};
  endfunction

  function automatic logic [63:0] observed();
    return pack(bus.row_sel, bus.col_out, bus.row_index, bus.frame_done);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic set_row(input int r, input logic [15:0] val);
    bus.data[(11 - r) * 16 +: 16] = val;
  endtask

  // Invariants checked on every falling edge.
  always @(negedge clk) begin
    if (!$onehot0(bus.row_sel)) onehot_viol <= onehot_viol + 1;
    if (bus.row_sel != '0 && bus.col_out != prev_col) stable_viol <= stable_viol + 1;
    if (bus.row_index >= 4'd12) index_viol <= index_viol + 1;
    if (bus.frame_done) fd_count <= fd_count + 1;
    prev_col <= bus.col_out;
  end

  initial begin
    logic [11:0] rs;
    int          p;
    int          r;
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    onehot_viol = 0;
    stable_viol = 0;
    index_viol  = 0;
    fd_count    = 0;
    prev_col    = '0;
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.data    = '0;
    repeat (3) step();
    check_val("reset_outputs", observed(), pack(12'h000, 16'h0000, 4'd0, 1'b0));
    check_val("reset_state", 64'(dut.state_q), 64'(StIdle));

    // 1: row 0 all on, other rows off.
    set_row(0, 16'hFFFF);
    rst        = 1'b0;
    bus.enable = 1'b1;
    t0         = cyc;
    step();
    check_val("t1_load_state", 64'(dut.state_q), 64'(StLoad));
    check_val("t1_load_out", observed(), pack(12'h000, 16'h0000, 4'd0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("t1_blank0", observed(), pack(12'h000, 16'hFFFF, 4'd0, 1'b0));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t1_drive0", observed(), pack(12'h001, 16'hFFFF, 4'd0, 1'b0));
    end
    step();
    check_val("t1_blank1", observed(), pack(12'h000, 16'h0000, 4'd1, 1'b0));

    // 2: walking ones, one full pass.
    bus.enable = 1'b0;
    step();
    check_val("t2_idle", observed(), pack(12'h000, 16'h0000, 4'd0, 1'b0));
    for (int i = 0; i < 12; i++) set_row(i, 16'(1) << i);
    bus.enable = 1'b1;
    t0         = cyc;
    for (int k = 1; k <= 74; k++) begin
      step();
      if (k == 1) begin
        check_val("t2_load", observed(), pack(12'h000, 16'h0000, 4'd0, 1'b0));
      end else if (k == 74) begin
        check_val("t2_frame_done", observed(), pack(12'h000, 16'h0800, 4'd0, 1'b1));
        check_val("t2_next_load", 64'(dut.state_q), 64'(StLoad));
      end else begin
        p  = k - 2;
        r  = p / 6;
        rs = (p % 6 < 2) ? 12'h000 : 12'(1) << r;
        check_val($sformatf("t2_k%0d", k), observed(), pack(rs, 16'(1) << r, 4'(r), 1'b0));
      end
    end

    // 3: change data during row 5 DRIVE of the second pass.
    l_pass = cyc;
    wait_until(l_pass + 33);
    check_val("t3_row5", observed(), pack(12'h020, 16'h0020, 4'd5, 1'b0));
    for (int i = 0; i < 12; i++) set_row(i, 16'hF000 | 16'(i));
    wait_until(l_pass + 37);
    check_val("t3_old_row6", observed(), pack(12'h000, 16'h0040, 4'd6, 1'b0));
    wait_until(l_pass + 69);
    check_val("t3_old_row11", observed(), pack(12'h800, 16'h0800, 4'd11, 1'b0));
    wait_until(l_pass + 73);
    check_val("t3_done", observed(), pack(12'h000, 16'h0800, 4'd0, 1'b1));
    l_pass = cyc;
    wait_until(l_pass + 2);
    check_val("t3_new_row0", observed(), pack(12'h000, 16'hF000, 4'd0, 1'b0));
    wait_until(l_pass + 9);
    check_val("t3_new_row1", observed(), pack(12'h002, 16'hF001, 4'd1, 1'b0));

    // 4: drop enable during row 3 DRIVE.
    wait_until(l_pass + 22);
    check_val("t4_row3", observed(), pack(12'h008, 16'hF003, 4'd3, 1'b0));
    bus.enable = 1'b0;
    fd_before  = fd_count;
    step();
    check_val("t4_off_out", observed(), pack(12'h000, 16'h0000, 4'd0, 1'b0));
    check_val("t4_off_state", 64'(dut.state_q), 64'(StIdle));
    repeat (10) step();
    check_val("t4_no_done", 64'(fd_count), 64'(fd_before));
    bus.enable = 1'b1;
    t0         = cyc;
    step();
    check_val("t4_reload", 64'(dut.state_q), 64'(StLoad));
    step();
    check_val("t4_blank0", observed(), pack(12'h000, 16'hF000, 4'd0, 1'b0));
    wait_until(t0 + 4);
    check_val("t4_drive0", observed(), pack(12'h001, 16'hF000, 4'd0, 1'b0));

    // 5: reset during row 2 DRIVE with enable held high.
    wait_until(t0 + 17);
    check_val("t5_row2", observed(), pack(12'h004, 16'hF002, 4'd2, 1'b0));
    rst = 1'b1;
    step();
    check_val("t5_rst_out", observed(), pack(12'h000, 16'h0000, 4'd0, 1'b0));
    check_val("t5_rst_state", 64'(dut.state_q), 64'(StIdle));
    rst = 1'b0;
    step();
    check_val("t5_load", 64'(dut.state_q), 64'(StLoad));
    step();
    check_val("t5_blank0", observed(), pack(12'h000, 16'hF000, 4'd0, 1'b0));

    // 6: invariants over the whole run.
    step();
    check_val("inv_onehot0", 64'(onehot_viol), 64'd0);
    check_val("inv_col_stable", 64'(stable_viol), 64'd0);
    check_val("inv_row_index", 64'(index_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
